// File: rtl/proc9_pkg.sv
// Shared definitions for the 9-bit processor control unit: instruction field
// layout, opcode encodings and the T-cycle state type.
package proc9_pkg;

    localparam int DATA_W = 9;

    localparam int III_MSB = 8;
    localparam int III_LSB = 6;
    localparam int XXX_MSB = 5;
    localparam int XXX_LSB = 3;
    localparam int YYY_MSB = 2;
    localparam int YYY_LSB = 0;

    localparam logic [2:0] OPC_MV   = 3'b000;
    localparam logic [2:0] OPC_MVI  = 3'b001;
    localparam logic [2:0] OPC_ADD  = 3'b010;
    localparam logic [2:0] OPC_SUB  = 3'b011;
    localparam logic [2:0] OPC_MVNZ = 3'b100;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tcycle_t;

endpackage

// File: rtl/proc9_dec3to8.sv
// 3-to-8 one-hot decoder with enable; all outputs are zero when disabled.
module proc9_dec3to8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/proc9_control_unit.sv
// Instruction sequencer for the 9-bit processor: latches IIIXXXYYY on Run and
// steps T0..T3 driving register enables and bus selects. Option: PROC9_MVNZ_EN.
module proc9_control_unit #(
    parameter int DATA_W = proc9_pkg::DATA_W,
    parameter int NREGS  = 8,
    parameter int OPC_W  = 3
) (
    input  logic              clock,
    input  logic              aReset,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    input  logic              G_zero,
    output logic [NREGS-1:0]  Rin,
    output logic [NREGS-1:0]  Rout,
    output logic              DINout,
    output logic              Gout,
    output logic              Ain,
    output logic              Gin,
    output logic              AddSub,
    output logic              Done,
    output logic              Busy
);

    import proc9_pkg::*;

    tcycle_t           tcycle;
    tcycle_t           tcycle_nxt;
    logic [DATA_W-1:0] ir;
    logic [OPC_W-1:0]  opc;
    logic [2:0]        fld_x;
    logic [2:0]        fld_y;

    logic              rin_en;
    logic              rout_en;
    logic              rout_use_y;
    logic [2:0]        rout_sel;

    assign opc   = ir[III_MSB:III_LSB];
    assign fld_x = ir[XXX_MSB:XXX_LSB];
    assign fld_y = ir[YYY_MSB:YYY_LSB];

    // State register: IR only captures in T0, so Run/DIN are ignored mid-instruction
    always_ff @(posedge clock or posedge aReset) begin
        if (aReset) begin
            tcycle <= T0;
            ir     <= '0;
        end else begin
            tcycle <= tcycle_nxt;
            if (tcycle == T0 && Run) begin
                ir <= DIN;
            end
        end
    end

    always_comb begin
        tcycle_nxt = T0;
        case (tcycle)
            T0:      tcycle_nxt = Run ? T1 : T0;
            T1:      tcycle_nxt = (opc == OPC_ADD || opc == OPC_SUB) ? T2 : T0;
            T2:      tcycle_nxt = T3;
            T3:      tcycle_nxt = T0;
            default: tcycle_nxt = T0;
        endcase
    end

    // Outputs decode purely from state, so reset clears them without waiting for a clock
    always_comb begin
        rin_en     = 1'b0;
        rout_en    = 1'b0;
        rout_use_y = 1'b0;
        DINout     = 1'b0;
        Gout       = 1'b0;
        Ain        = 1'b0;
        Gin        = 1'b0;
        AddSub     = 1'b0;
        Done       = 1'b0;
        case (tcycle)
            T1: begin
                case (opc)
                    OPC_MV: begin
                        rout_en    = 1'b1;
                        rout_use_y = 1'b1;
                        rin_en     = 1'b1;
                        Done       = 1'b1;
                    end
                    OPC_MVI: begin
                        DINout = 1'b1;
                        rin_en = 1'b1;
                        Done   = 1'b1;
                    end
                    OPC_ADD, OPC_SUB: begin
                        rout_en = 1'b1;
                        Ain     = 1'b1;
                    end
`ifdef PROC9_MVNZ_EN
                    OPC_MVNZ: begin
                        rout_en    = 1'b1;
                        rout_use_y = 1'b1;
                        rin_en     = !G_zero;
                        Done       = 1'b1;
                    end
`endif
                    default: Done = 1'b1;
                endcase
            end
            T2: begin
                rout_en    = 1'b1;
                rout_use_y = 1'b1;
                Gin        = 1'b1;
                AddSub     = ir[III_LSB];
            end
            T3: begin
                Gout   = 1'b1;
                rin_en = 1'b1;
                Done   = 1'b1;
            end
            default: ;
        endcase
    end

`ifndef PROC9_MVNZ_EN
    logic unused_g_zero;
    assign unused_g_zero = G_zero;
`endif

    assign rout_sel = rout_use_y ? fld_y : fld_x;
    assign Busy     = (tcycle != T0);

    proc9_dec3to8 u_dec_rin (
        .en     (rin_en),
        .sel    (fld_x),
        .onehot (Rin)
    );

    proc9_dec3to8 u_dec_rout (
        .en     (rout_en),
        .sel    (rout_sel),
        .onehot (Rout)
    );

endmodule

// File: tb/tb_proc9_control_unit.sv
// Directed self-checking bench for proc9_control_unit; expectations follow the
// PROC9_MVNZ_EN setting of the build.
module tb_proc9_control_unit;

    logic       clock = 1'b0;
    logic       aReset;
    logic       Run;
    logic [8:0] DIN;
    logic       G_zero;
    logic [7:0] Rin;
    logic [7:0] Rout;
    logic       DINout;
    logic       Gout;
    logic       Ain;
    logic       Gin;
    logic       AddSub;
    logic       Done;
    logic       Busy;

    int checks = 0;
    int errors = 0;

    proc9_control_unit dut (
        .clock  (clock),
        .aReset (aReset),
        .Run    (Run),
        .DIN    (DIN),
        .G_zero (G_zero),
        .Rin    (Rin),
        .Rout   (Rout),
        .DINout (DINout),
        .Gout   (Gout),
        .Ain    (Ain),
        .Gin    (Gin),
        .AddSub (AddSub),
        .Done   (Done),
        .Busy   (Busy)
    );

    always #5 clock = ~clock;

    // Packed order: Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done, Busy
    function automatic logic [22:0] outs(input logic [7:0] rin, input logic [7:0] rout,
                                         input logic dinout, input logic gout, input logic ain,
                                         input logic gin, input logic addsub, input logic done,
                                         input logic busy);
        return {rin, rout, dinout, gout, ain, gin, addsub, done, busy};
    endfunction

    task automatic expect_outs(input string tag, input logic [22:0] exp);
        logic [22:0] obs;
        obs = {Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done, Busy};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        checks++;
        assert ((($countones(Rout) + int'(DINout) + int'(Gout)) <= 1) && $onehot0(Rin)) else begin
            errors++;
            $error("FAIL %s_bus: Rout=%h DINout=%b Gout=%b Rin=%h (need single bus driver, Rin one-hot or zero)",
                   tag, Rout, DINout, Gout, Rin);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    localparam logic [22:0] IDLE = 23'd0;

    initial begin
        aReset = 1'b1;
        Run    = 1'b0;
        DIN    = '0;
        G_zero = 1'b0;
        tick();
        tick();
        expect_outs("reset_hold", IDLE);
        aReset = 1'b0;
        tick();
        expect_outs("idle_after_reset", IDLE);

        // mv R1,R0
        Run = 1'b1; DIN = 9'b000_001_000;
        tick();
        Run = 1'b0;
        expect_outs("mv_t1", outs(8'h02, 8'h01, 0, 0, 0, 0, 0, 1, 1));
        tick();
        expect_outs("mv_back_t0", IDLE);

        // mvi R5,#0x1A5
        Run = 1'b1; DIN = 9'b001_101_000;
        tick();
        Run = 1'b0; DIN = 9'h1A5;
        expect_outs("mvi_t1", outs(8'h20, 8'h00, 1, 0, 0, 0, 0, 1, 1));
        tick();
        expect_outs("mvi_back_t0", IDLE);

        // sub R2,R7
        Run = 1'b1; DIN = 9'b011_010_111;
        tick();
        Run = 1'b0;
        expect_outs("sub_t1", outs(8'h00, 8'h04, 0, 0, 1, 0, 0, 0, 1));
        tick();
        expect_outs("sub_t2", outs(8'h00, 8'h80, 0, 0, 0, 1, 1, 0, 1));
        tick();
        expect_outs("sub_t3", outs(8'h04, 8'h00, 0, 1, 0, 0, 0, 1, 1));
        tick();
        expect_outs("sub_back_t0", IDLE);

        // add R2,R2: X==Y, AddSub stays 0
        Run = 1'b1; DIN = 9'b010_010_010;
        tick();
        Run = 1'b0;
        expect_outs("addxx_t1", outs(8'h00, 8'h04, 0, 0, 1, 0, 0, 0, 1));
        tick();
        expect_outs("addxx_t2", outs(8'h00, 8'h04, 0, 0, 0, 1, 0, 0, 1));
        tick();
        expect_outs("addxx_t3", outs(8'h04, 8'h00, 0, 1, 0, 0, 0, 1, 1));
        tick();

        // Run held high: add R3,R1 ; mv R4,R3 ; mvi R6,#0x0AA -> Done on cycles 4, 6, 8
        Run = 1'b1; DIN = 9'b010_011_001;
        tick();
        DIN = 9'b000_100_011;
        expect_outs("b2b_c2_add_t1", outs(8'h00, 8'h08, 0, 0, 1, 0, 0, 0, 1));
        tick();
        expect_outs("b2b_c3_add_t2", outs(8'h00, 8'h02, 0, 0, 0, 1, 0, 0, 1));
        tick();
        expect_outs("b2b_c4_add_t3", outs(8'h08, 8'h00, 0, 1, 0, 0, 0, 1, 1));
        tick();
        expect_outs("b2b_c5_t0", IDLE);
        tick();
        DIN = 9'b001_110_000;
        expect_outs("b2b_c6_mv_t1", outs(8'h10, 8'h08, 0, 0, 0, 0, 0, 1, 1));
        tick();
        expect_outs("b2b_c7_t0", IDLE);
        tick();
        Run = 1'b0; DIN = 9'h0AA;
        expect_outs("b2b_c8_mvi_t1", outs(8'h40, 8'h00, 1, 0, 0, 0, 0, 1, 1));
        tick();
        expect_outs("b2b_c9_t0", IDLE);

        // Opcode 100 with G_zero low then high
        G_zero = 1'b0; Run = 1'b1; DIN = 9'b100_011_101;
        tick();
        Run = 1'b0;
`ifdef PROC9_MVNZ_EN
        expect_outs("op100_gz0", outs(8'h08, 8'h20, 0, 0, 0, 0, 0, 1, 1));
`else
        expect_outs("op100_gz0", outs(8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1));
`endif
        tick();
        expect_outs("op100_back_t0", IDLE);
        G_zero = 1'b1; Run = 1'b1;
        tick();
        Run = 1'b0;
`ifdef PROC9_MVNZ_EN
        expect_outs("op100_gz1", outs(8'h00, 8'h20, 0, 0, 0, 0, 0, 1, 1));
`else
        expect_outs("op100_gz1", outs(8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1));
`endif
        tick();
        G_zero = 1'b0;

        // Opcode 111 is always a no-op
        Run = 1'b1; DIN = 9'b111_110_001;
        tick();
        Run = 1'b0;
        expect_outs("nop111_t1", outs(8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1));
        tick();
        expect_outs("nop111_back_t0", IDLE);

        // Reset asserted in T2 of add R0,R1 aborts at once
        Run = 1'b1; DIN = 9'b010_000_001;
        tick();
        Run = 1'b0;
        expect_outs("rst_add_t1", outs(8'h00, 8'h01, 0, 0, 1, 0, 0, 0, 1));
        tick();
        expect_outs("rst_add_t2", outs(8'h00, 8'h02, 0, 0, 0, 1, 0, 0, 1));
        aReset = 1'b1;
        #1;
        expect_outs("rst_async", IDLE);
        tick();
        expect_outs("rst_held", IDLE);
        aReset = 1'b0;
        tick();
        expect_outs("rst_released", IDLE);

        // Recovery after reset: mv R7,R6
        Run = 1'b1; DIN = 9'b000_111_110;
        tick();
        Run = 1'b0;
        expect_outs("post_rst_mv_t1", outs(8'h80, 8'h40, 0, 0, 0, 0, 0, 1, 1));
        tick();
        expect_outs("post_rst_t0", IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
